// File: rtl/binary_game_timed.sv
// Binary-number game: ring menu, timed Play and untimed Practice rounds.
// LFSR-sourced WIDTH-bit targets, saturating score and Play high score.
module binary_game_timed #(
    parameter int          WIDTH       = 8,
    parameter int          SCORE_W     = 8,
    parameter int          ROUND_TICKS = 1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         TW          = $clog2(ROUND_TICKS + 1)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               CEN,
    input  logic               Select,
    input  logic               Quit,
    input  logic               selectLeft,
    input  logic               selectRight,
    input  logic [WIDTH-1:0]   userNumber,
    output logic [WIDTH-1:0]   outputNumber,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] highScore,
    output logic [TW-1:0]      timeLeft,
    output logic               practiceMode,
    output logic               correctPulse,
    output logic               wrongPulse,
    output logic [9:0]         q_state
);

    localparam int S_INIT   = 0;
    localparam int S_MPLAY  = 1;
    localparam int S_MPRAC  = 2;
    localparam int S_MSCORE = 3;
    localparam int S_MQUIT  = 4;
    localparam int S_RSTART = 5;
    localparam int S_ROUND  = 6;
    localparam int S_RDONE  = 7;
    localparam int S_SCORES = 8;
    localparam int S_DONE   = 9;

    localparam logic [9:0] ST_INIT   = 10'b00_0000_0001;
    localparam logic [9:0] ST_MPLAY  = 10'b00_0000_0010;
    localparam logic [9:0] ST_MPRAC  = 10'b00_0000_0100;
    localparam logic [9:0] ST_MSCORE = 10'b00_0000_1000;
    localparam logic [9:0] ST_MQUIT  = 10'b00_0001_0000;
    localparam logic [9:0] ST_RSTART = 10'b00_0010_0000;
    localparam logic [9:0] ST_ROUND  = 10'b00_0100_0000;
    localparam logic [9:0] ST_RDONE  = 10'b00_1000_0000;
    localparam logic [9:0] ST_SCORES = 10'b01_0000_0000;
    localparam logic [9:0] ST_DONE   = 10'b10_0000_0000;

    localparam logic [TW-1:0]      RT      = TW'(ROUND_TICKS);
    localparam logic [SCORE_W-1:0] SC_MAX  = {SCORE_W{1'b1}};
    localparam logic [15:0]        TAPS    = 16'hB400;

    logic [9:0]         state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hs_q, hs_d;
    logic [TW-1:0]      time_q, time_d;
    logic               prac_q, prac_d;
    logic               cp_q, cp_d;
    logic               wp_q, wp_d;

    logic legal, multi, hit, in_round, menu_sel;

    assign legal    = (state_q != '0) &&
                      ((state_q & (state_q - 10'd1)) == '0);
    assign multi    = (Select & selectLeft) | (Select & selectRight) |
                      (selectLeft & selectRight);
    assign hit      = (userNumber == target_q);
    assign in_round = legal && state_q[S_ROUND];
    assign menu_sel = CEN && Select && !multi;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_INIT;
            lfsr_q   <= LFSR_SEED;
            target_q <= '0;
            score_q  <= '0;
            hs_q     <= '0;
            time_q   <= '0;
            prac_q   <= 1'b0;
            cp_q     <= 1'b0;
            wp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            score_q  <= score_d;
            hs_q     <= hs_d;
            time_q   <= time_d;
            prac_q   <= prac_d;
            cp_q     <= cp_d;
            wp_q     <= wp_d;
        end
    end

    // Corrupted state recovers immediately, regardless of CEN.
    always_comb begin
        state_d = state_q;
        if (!legal) begin
            state_d = ST_INIT;
        end else if (CEN) begin
            unique case (1'b1)
                state_q[S_INIT]:
                    if (Select) state_d = ST_MPLAY;
                state_q[S_MPLAY]:
                    if (!multi) begin
                        if (Select)           state_d = ST_RSTART;
                        else if (selectRight) state_d = ST_MPRAC;
                        else if (selectLeft)  state_d = ST_MQUIT;
                    end
                state_q[S_MPRAC]:
                    if (!multi) begin
                        if (Select)           state_d = ST_RSTART;
                        else if (selectRight) state_d = ST_MSCORE;
                        else if (selectLeft)  state_d = ST_MPLAY;
                    end
                state_q[S_MSCORE]:
                    if (!multi) begin
                        if (Select)           state_d = ST_SCORES;
                        else if (selectRight) state_d = ST_MQUIT;
                        else if (selectLeft)  state_d = ST_MPRAC;
                    end
                state_q[S_MQUIT]:
                    if (!multi) begin
                        if (Select)           state_d = ST_DONE;
                        else if (selectRight) state_d = ST_MPLAY;
                        else if (selectLeft)  state_d = ST_MSCORE;
                    end
                state_q[S_RSTART]:
                    state_d = ST_ROUND;
                state_q[S_ROUND]:
                    if (Quit)
                        state_d = ST_RDONE;
                    else if (Select)
                        state_d = hit    ? ST_RSTART :
                                  prac_q ? ST_ROUND  : ST_RDONE;
                    else if (!prac_q && time_q <= TW'(1))
                        state_d = ST_RDONE;
                state_q[S_RDONE]:
                    if (Select) state_d = ST_SCORES;
                state_q[S_SCORES]:
                    if (Quit) state_d = ST_MSCORE;
                state_q[S_DONE]:
                    if (Select) state_d = ST_INIT;
                default:
                    state_d = ST_INIT;
            endcase
        end
    end

    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0);
        target_d = target_q;
        score_d  = score_q;
        hs_d     = hs_q;
        time_d   = time_q;
        prac_d   = prac_q;
        cp_d     = 1'b0;
        wp_d     = 1'b0;
        if (legal && menu_sel && state_q[S_MPLAY]) begin
            score_d = '0;
            prac_d  = 1'b0;
        end
        if (legal && menu_sel && state_q[S_MPRAC]) begin
            score_d = '0;
            prac_d  = 1'b1;
        end
        if (legal && CEN && state_q[S_RSTART]) begin
            target_d = lfsr_q[WIDTH-1:0];
            time_d   = RT;
        end
        if (in_round && CEN) begin
            if (Quit) begin
                time_d = time_q;
            end else if (Select) begin
                cp_d = hit;
                wp_d = !hit;
                if (hit && score_q != SC_MAX)
                    score_d = score_q + SCORE_W'(1);
            end else if (!prac_q && time_q != '0) begin
                time_d = time_q - TW'(1);
            end
            // Score never changes on the way into ROUND_DONE.
            if (state_d == ST_RDONE && !prac_q && score_q > hs_q)
                hs_d = score_q;
        end
    end

    always_comb begin
        outputNumber = in_round ? target_q : '0;
        score        = score_q;
        highScore    = hs_q;
        timeLeft     = time_q;
        practiceMode = prac_q;
        correctPulse = cp_q;
        wrongPulse   = wp_q;
        q_state      = state_q;
    end

endmodule

// File: tb/tb_binary_game_timed.sv
// Directed bench for binary_game_timed: two instances (8-bit/8-bit score
// and 4-bit/2-bit score) share controls and follow the same state path.
module tb_binary_game_timed;

    localparam logic [9:0] INIT  = 10'h001;
    localparam logic [9:0] MPLAY = 10'h002;
    localparam logic [9:0] MPRAC = 10'h004;
    localparam logic [9:0] MSC   = 10'h008;
    localparam logic [9:0] MQUIT = 10'h010;
    localparam logic [9:0] RST   = 10'h020;
    localparam logic [9:0] RND   = 10'h040;
    localparam logic [9:0] RDN   = 10'h080;
    localparam logic [9:0] SCR   = 10'h100;
    localparam logic [9:0] DN    = 10'h200;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       CEN = 1'b1;
    logic       Select = 1'b0;
    logic       Quit = 1'b0;
    logic       sL = 1'b0;
    logic       sR = 1'b0;
    logic [7:0] un8 = '0;
    logic [3:0] un4 = '0;

    logic [7:0] on8, sc8, hs8;
    logic [3:0] on4;
    logic [1:0] sc4, hs4;
    logic [2:0] tl8, tl4;
    logic       pm8, pm4, cp8, cp4, wp8, wp4;
    logic [9:0] qs8, qs4;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] lm;
    logic [15:0] et;

    binary_game_timed #(
        .WIDTH(8), .SCORE_W(8), .ROUND_TICKS(4), .LFSR_SEED(16'hACE1)
    ) u_d8 (
        .Clk(Clk), .Reset_n(Reset_n), .CEN(CEN), .Select(Select),
        .Quit(Quit), .selectLeft(sL), .selectRight(sR),
        .userNumber(un8), .outputNumber(on8), .score(sc8),
        .highScore(hs8), .timeLeft(tl8), .practiceMode(pm8),
        .correctPulse(cp8), .wrongPulse(wp8), .q_state(qs8)
    );

    binary_game_timed #(
        .WIDTH(4), .SCORE_W(2), .ROUND_TICKS(4), .LFSR_SEED(16'hACE1)
    ) u_d4 (
        .Clk(Clk), .Reset_n(Reset_n), .CEN(CEN), .Select(Select),
        .Quit(Quit), .selectLeft(sL), .selectRight(sR),
        .userNumber(un4), .outputNumber(on4), .score(sc4),
        .highScore(hs4), .timeLeft(tl4), .practiceMode(pm4),
        .correctPulse(cp4), .wrongPulse(wp4), .q_state(qs4)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) lm <= 16'hACE1;
        else          lm <= (lm >> 1) ^ (lm[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic step(input logic s, input logic q,
                        input logic l, input logic r);
        Select = s; Quit = q; sL = l; sR = r;
        tick();
        Select = 0; Quit = 0; sL = 0; sR = 0;
    endtask

    task automatic st(input string tag, input logic [9:0] e);
        check({tag, ".q8"}, qs8, e);
        check({tag, ".q4"}, qs4, e);
    endtask

    task automatic sc(input string tag, input int e8, input int e4);
        check({tag, ".sc8"}, sc8, e8);
        check({tag, ".sc4"}, sc4, e4);
    endtask

    task automatic hs(input string tag, input int e8, input int e4);
        check({tag, ".hs8"}, hs8, e8);
        check({tag, ".hs4"}, hs4, e4);
    endtask

    task automatic enter_round(input string tag);
        et = lm;
        tick();
        st(tag, RND);
        check({tag, ".on8"}, on8, et[7:0]);
        check({tag, ".on4"}, on4, et[3:0]);
    endtask

    task automatic answer(input logic ok);
        un8 = ok ? et[7:0] : ~et[7:0];
        un4 = ok ? et[3:0] : ~et[3:0];
        step(1, 0, 0, 0);
    endtask

    task automatic reset_vals(input string tag);
        st(tag, INIT);
        sc(tag, 0, 0);
        hs(tag, 0, 0);
        check({tag, ".on8"}, on8, 0);
        check({tag, ".on4"}, on4, 0);
        check({tag, ".tl8"}, tl8, 0);
        check({tag, ".pm8"}, pm8, 0);
    endtask

    initial begin
        repeat (3) tick();
        reset_vals("rst");
        Reset_n = 1'b1;

        step(1, 0, 0, 0); st("t2.sel", MPLAY);
        step(0, 0, 1, 0); st("t2.left", MQUIT);
        step(0, 0, 0, 1); st("t2.right", MPLAY);
        step(1, 0, 0, 1); st("t2.multi", MPLAY);
        CEN = 0;
        step(0, 0, 0, 1); st("t2.cen0", MPLAY);
        CEN = 1;
        step(0, 0, 0, 1); st("t2.r2", MPRAC);
        step(0, 0, 1, 0); st("t2.l2", MPLAY);

        step(1, 0, 0, 0); st("t3.go", RST);
        check("t3.pm", pm8, 0);
        sc("t3.clr", 0, 0);
        for (int i = 0; i < 3; i++) begin
            enter_round("t3.rnd");
            check("t3.tl", tl8, 4);
            answer(1);
            st("t3.ok", RST);
            check("t3.cp8", cp8, 1);
            check("t3.cp4", cp4, 1);
            sc("t3.inc", i + 1, i + 1);
        end
        enter_round("t3.rnd");
        check("t3.cp0", cp8, 0);
        answer(0);
        st("t3.bad", RDN);
        check("t3.wp8", wp8, 1);
        check("t3.wp4", wp4, 1);
        sc("t3.end", 3, 3);
        hs("t3.hs", 3, 3);
        tick();
        check("t3.wp0", wp8, 0);
        st("t3.hold", RDN);
        step(1, 0, 0, 0); st("t3.scr", SCR);
        sc("t3.show", 3, 3);
        step(0, 1, 0, 0); st("t3.msc", MSC);
        step(0, 0, 1, 0); st("t3.mpr", MPRAC);
        step(0, 0, 1, 0); st("t3.mpl", MPLAY);

        step(1, 0, 0, 0); st("t4.go", RST);
        enter_round("t4.rnd");
        check("t4.tl0", tl8, 4);
        for (int i = 1; i <= 3; i++) begin
            tick();
            st("t4.wait", RND);
            check("t4.tl", tl8, 4 - i);
        end
        tick();
        st("t4.tout", RDN);
        check("t4.tlz", tl8, 0);
        sc("t4.sc", 0, 0);
        hs("t4.hs", 3, 3);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0); st("t4.back", MPLAY);
        step(1, 0, 0, 0);
        enter_round("t4.rnd2");
        repeat (3) tick();
        check("t4.tl1", tl8, 1);
        answer(1);
        st("t4.last", RST);
        check("t4.cp", cp8, 1);
        sc("t4.sc1", 1, 1);
        enter_round("t4.rnd3");
        check("t4.reload", tl8, 4);
        step(0, 1, 0, 0); st("t4.quit", RDN);
        hs("t4.hs2", 3, 3);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0); st("t5.menu", MPRAC);

        step(1, 0, 0, 0); st("t5.go", RST);
        check("t5.pm8", pm8, 1);
        check("t5.pm4", pm4, 1);
        sc("t5.clr", 0, 0);
        for (int i = 1; i <= 5; i++) begin
            enter_round("t5.rnd");
            answer(1);
            sc("t5.inc", i, (i > 3) ? 3 : i);
        end
        enter_round("t5.rnd");
        answer(0);
        st("t5.stay", RND);
        check("t5.wp", wp8, 1);
        sc("t5.keep", 5, 3);
        repeat (6) tick();
        st("t5.notime", RND);
        check("t5.tl", tl8, 4);
        CEN = 0;
        step(0, 1, 0, 0); st("t5.cen0", RND);
        CEN = 1;
        step(0, 1, 0, 0); st("t5.quit", RDN);
        hs("t5.hs", 3, 3);
        check("t5.pm", pm8, 1);

        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0); st("t1.menu", MPLAY);
        step(1, 0, 0, 0);
        enter_round("t1.rnd");
        answer(1);
        enter_round("t1.rnd2");
        sc("t1.pre", 1, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        reset_vals("t1.async");
        tick();
        Reset_n = 1'b1;

        step(1, 0, 0, 0); st("fin.mpl", MPLAY);
        step(0, 0, 1, 0); st("fin.mq", MQUIT);
        step(1, 0, 0, 0); st("fin.done", DN);
        step(1, 0, 0, 0); st("fin.init", INIT);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
